// File: rtl/bus_wait_memory_pkg.sv
// ----------------------------------------------------------------------------
// bus_mem_pkg: shared types and helpers for bus_wait_memory | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bus_mem_pkg;

  typedef enum logic [1:0] {
    WAIT_NONE   = 2'd0,
    WAIT_FIXED  = 2'd1,
    WAIT_RANDOM = 2'd2
  } wait_mode_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [3:0]  byteenable;
  } bus_req_t;

  function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

  function automatic logic [31:0] word_to_byte(input logic [31:0] word_addr);
    return {word_addr[29:0], 2'b00};
  endfunction

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr16_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // Smallest 2^k-1 that covers max_wait.
  function automatic logic [15:0] wait_mask(input int unsigned max_wait);
    int unsigned m;
    m = 0;
    for (int i = 0; i < 16; i++) begin
      if (m < max_wait) m = (m << 1) | 1;
    end
    return m[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_wait_memory_if.sv
// ----------------------------------------------------------------------------
// bus_wait_memory_if: Avalon-style CPU data bus | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bus_wait_memory_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output read, write, address, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  read, write, address, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

`default_nettype wire

// File: rtl/bus_wait_memory_lfsr16.sv
// ----------------------------------------------------------------------------
// lfsr16: 16-bit Galois LFSR, steps once per advance pulse | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lfsr16
  import bus_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = advance ? lfsr16_step(value_q) : value_q;
  end

  always_ff @(posedge clk) begin
    if (reset) value_q <= seed;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

`default_nettype wire

// File: rtl/bus_wait_memory.sv
// ----------------------------------------------------------------------------
// bus_wait_memory: word RAM on the CPU bus with wait states and fault flag | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_wait_memory
  import bus_mem_pkg::*;
#(
  parameter int unsigned WORDS       = 1024,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int unsigned WAIT_MODE   = 0,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned MAX_WAIT    = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  bus_wait_memory_if.slave   bus,
  output logic               fault,
  output logic [31:0]        access_count
);

  localparam int unsigned ADDR_W    = $clog2(WORDS);
  localparam wait_mode_t  MODE      = wait_mode_t'(WAIT_MODE[1:0]);
  localparam logic [15:0] WAIT_MASK = wait_mask(MAX_WAIT);

  function automatic logic [15:0] wait_value(input logic [15:0] lfsr);
    logic [15:0] masked;
    masked = lfsr & WAIT_MASK;
    case (MODE)
      WAIT_NONE:  return 16'd0;
      WAIT_FIXED: return WAIT_CYCLES[15:0];
      default:    return ({16'd0, masked} > MAX_WAIT) ? MAX_WAIT[15:0] : masked;
    endcase
  endfunction

  logic [31:0]       mem_q [WORDS];
  logic [15:0]       cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic [31:0]       count_q, count_d;
  bus_req_t          shadow_q, req_now;
  logic              shadow_vld_q;
  logic [15:0]       lfsr_value;

  logic              req, stalled, complete;
  logic              aligned, in_range, conflict, access_ok, changed;
  logic [31:0]       word_off;
  logic [ADDR_W-1:0] idx;

  always_comb begin
    req_now  = '{read: bus.read, write: bus.write,
                 address: bus.address, byteenable: bus.byteenable};
    req      = bus.read | bus.write;
    stalled  = req && (cnt_q != 16'd0);
    complete = req && (cnt_q == 16'd0);
    word_off = byte_to_word(bus.address - BASE_ADDR);
    in_range = (word_off >> ADDR_W) == 32'd0;
    idx      = word_off[ADDR_W-1:0];
    aligned  = bus.address[1:0] == 2'b00;
    conflict = bus.read && bus.write;
    access_ok = in_range && aligned && !conflict;
    // Anything the master moved after being told to wait is a protocol error.
    changed  = shadow_vld_q && (req_now != shadow_q);
  end

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (complete && (MODE == WAIT_RANDOM)),
    .seed    (LFSR_SEED),
    .value   (lfsr_value)
  );

  always_comb begin
    cnt_d   = cnt_q;
    count_d = count_q;
    fault_d = fault_q | changed;
    if (stalled) begin
      cnt_d = cnt_q - 16'd1;
    end else if (complete) begin
      // Reload from the value the LFSR steps to on this same edge.
      cnt_d   = wait_value(lfsr16_step(lfsr_value));
      count_d = count_q + 32'd1;
      if (!access_ok) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= wait_value(LFSR_SEED);
      fault_q      <= 1'b0;
      count_q      <= 32'd0;
      shadow_vld_q <= 1'b0;
      shadow_q     <= '0;
    end else begin
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
      count_q      <= count_d;
      shadow_vld_q <= stalled;
      shadow_q     <= req_now;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && complete && bus.write && access_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i]) mem_q[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
  end

  assign bus.readdata    = (!reset && complete && bus.read && access_ok) ? mem_q[idx] : 32'd0;
  assign bus.waitrequest = stalled;
  assign fault           = fault_q;
  assign access_count    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_wait_memory.sv
// ----------------------------------------------------------------------------
// tb_bus_wait_memory: three wait modes side by side against a behavioural model | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bus_wait_memory;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int unsigned SEED = 32'hACE1;

  logic clk;
  logic rst;
  logic        rd   [3];
  logic        wr   [3];
  logic [31:0] ad   [3];
  logic [3:0]  be   [3];
  logic [31:0] wd   [3];
  logic [31:0] rdat [3];
  logic        wq   [3];
  logic        flt  [3];
  logic [31:0] cnt  [3];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: no waits, dut1: fixed 2, dut2: random 0..3
  for (genvar g = 0; g < 3; g++) begin : g_dut
    bus_wait_memory_if u_if ();
    assign u_if.read       = rd[g];
    assign u_if.write      = wr[g];
    assign u_if.address    = ad[g];
    assign u_if.byteenable = be[g];
    assign u_if.writedata  = wd[g];
    assign rdat[g]         = u_if.readdata;
    assign wq[g]           = u_if.waitrequest;

    bus_wait_memory #(
      .WORDS(1024), .INIT_FILE(""), .BASE_ADDR(BASE), .WAIT_MODE(g),
      .WAIT_CYCLES(2), .MAX_WAIT(3), .LFSR_SEED(16'hACE1)
    ) u_dut (
      .clk(clk), .reset(rst), .bus(u_if.slave),
      .fault(flt[g]), .access_count(cnt[g])
    );
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, k, act, exp_v, $time);
    end
  endtask

  // Behavioural model
  int unsigned left [3];
  int unsigned lf   [3];
  logic [31:0] ecount [3];
  logic        efault [3];
  logic        pstall [3];
  logic        prd [3], pwr [3];
  logic [31:0] pad [3];
  logic [3:0]  pbe [3];
  logic [31:0] mmem [3][1024];
  bit          mval [3][1024];

  function automatic int unsigned lfsr_next(input int unsigned v);
    return (v & 1) ? ((v >> 1) ^ 32'hB400) : (v >> 1);
  endfunction

  function automatic int unsigned wait_of(input int k, input int unsigned v);
    int unsigned m;
    if (k == 0) return 0;
    if (k == 1) return 2;
    m = v & 3;
    return (m > 3) ? 3 : m;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        left[k] = wait_of(k, SEED);
        lf[k] = SEED;
        ecount[k] = 0;
        efault[k] = 1'b0;
        pstall[k] = 1'b0;
      end else begin
        logic req, ok, inr;
        longint off;
        int idx;
        chk("access_count", k, cnt[k], ecount[k]);
        chk("fault", k, {31'd0, flt[k]}, {31'd0, efault[k]});
        req = rd[k] | wr[k];
        if (pstall[k] && (rd[k] != prd[k] || wr[k] != pwr[k] || ad[k] != pad[k] || be[k] != pbe[k]))
          efault[k] = 1'b1;
        chk("waitrequest", k, {31'd0, wq[k]}, {31'd0, req && (left[k] != 0)});
        if (req && left[k] != 0) begin
          left[k]--;
          pstall[k] = 1'b1;
          prd[k] = rd[k]; pwr[k] = wr[k]; pad[k] = ad[k]; pbe[k] = be[k];
          chk("readdata_idle", k, rdat[k], 32'd0);
        end else begin
          pstall[k] = 1'b0;
          if (req) begin
            off = longint'(ad[k]) - longint'(BASE);
            inr = (off >= 0) && (off < 4096);
            ok  = inr && (ad[k][1:0] == 2'b00) && !(rd[k] && wr[k]);
            idx = inr ? int'(off / 4) : 0;
            if (rd[k] && !wr[k] && ok) begin
              if (mval[k][idx]) chk("readdata", k, rdat[k], mmem[k][idx]);
            end else begin
              chk("readdata_zero", k, rdat[k], 32'd0);
            end
            if (wr[k] && !rd[k] && ok) begin
              for (int i = 0; i < 4; i++)
                if (be[k][i]) mmem[k][idx][8*i +: 8] = wd[k][8*i +: 8];
              if (be[k] == 4'hF) mval[k][idx] = 1'b1;
            end
            ecount[k]++;
            if (!ok) efault[k] = 1'b1;
            if (k == 2) lf[k] = lfsr_next(lf[k]);
            left[k] = wait_of(k, lf[k]);
          end else begin
            chk("readdata_idle", k, rdat[k], 32'd0);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the completion edge.
  task automatic access(input int k, input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        output int stalls, output logic [31:0] rdata);
    bit done;
    rd[k] = r; wr[k] = w; ad[k] = a; be[k] = b; wd[k] = d;
    stalls = 0; rdata = 32'd0; done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!wq[k]) begin
        rdata = rdat[k];
        done = 1;
      end else begin
        stalls++;
      end
    end
    if (!done) chk("access_timeout", k, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [31:0] rv;
    int pin [5] = '{1, 0, 0, 0, 2};
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 0; wr[k] = 0; ad[k] = BASE; be[k] = 4'hF; wd[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_count", k, cnt[k], 32'd0);
      chk("reset_fault", k, {31'd0, flt[k]}, 32'd0);
      chk("reset_rdata", k, rdat[k], 32'd0);
    end
    @(posedge clk); #1;

    // Random-wait reads: stall sequence follows the seeded LFSR
    for (int i = 0; i < 20; i++) begin
      access(2, 1, 0, BASE + 4 * $urandom_range(0, 1023), 4'hF, 0, st, rv);
      chk("stall_range", 2, (st <= 3) ? 32'd1 : 32'd0, 32'd1);
      if (i < 5) chk("stall_pin", 2, st, pin[i]);
    end
    chk("count_20", 2, cnt[2], 32'd20);

    // Zero-wait write then read of word 0
    access(0, 0, 1, BASE, 4'hF, 32'h24020005, st, rv);
    chk("m0_wstall", 0, st, 0);
    access(0, 1, 0, BASE, 4'hF, 0, st, rv);
    chk("m0_rstall", 0, st, 0);
    chk("m0_rdata", 0, rv, 32'h24020005);
    chk("m0_count", 0, cnt[0], 32'd2);

    // Fixed waits with a partial write
    access(1, 0, 1, BASE + 4, 4'hF, 32'd0, st, rv);
    access(1, 0, 1, BASE + 4, 4'b0101, 32'hDEADBEEF, st, rv);
    chk("m1_wstall", 1, st, 2);
    access(1, 1, 0, BASE + 4, 4'hF, 0, st, rv);
    chk("m1_rstall", 1, st, 2);
    chk("m1_rdata", 1, rv, 32'h00AD00EF);

    // Random traffic over a small window, every word initialised first
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 16; w++)
        access(k, 0, 1, BASE + 4 * w, 4'hF, $urandom, st, rv);
    for (int n = 0; n < 60; n++) begin
      int k;
      logic r;
      k = $urandom_range(0, 2);
      r = 1'($urandom_range(0, 1));
      access(k, r, !r, BASE + 4 * $urandom_range(0, 15), 4'($urandom_range(0, 15)), $urandom, st, rv);
    end

    // Range and alignment faults
    chk("pre_fault0", 0, {31'd0, flt[0]}, 32'd0);
    access(0, 1, 0, 32'h00000000, 4'hF, 0, st, rv);
    chk("oor_rdata", 0, rv, 32'd0);
    chk("oor_fault", 0, {31'd0, flt[0]}, 32'd1);
    access(0, 1, 0, BASE + 2, 4'hF, 0, st, rv);
    chk("mis_rdata", 0, rv, 32'd0);
    chk("mis_fault", 0, {31'd0, flt[0]}, 32'd1);

    // Address moved during a stall
    chk("pre_fault1", 1, {31'd0, flt[1]}, 32'd0);
    rd[1] = 1; wr[1] = 0; ad[1] = BASE; be[1] = 4'hF;
    @(negedge clk);
    @(posedge clk); #1 ad[1] = BASE + 8;
    access(1, 1, 0, BASE + 8, 4'hF, 0, st, rv);
    chk("chg_fault", 1, {31'd0, flt[1]}, 32'd1);

    // Simultaneous read and write leaves memory alone
    chk("pre_fault2", 2, {31'd0, flt[2]}, 32'd0);
    access(2, 0, 1, BASE + 32, 4'hF, 32'h55AA55AA, st, rv);
    access(2, 1, 1, BASE + 32, 4'hF, 32'h00000000, st, rv);
    chk("rw_rdata", 2, rv, 32'd0);
    chk("rw_fault", 2, {31'd0, flt[2]}, 32'd1);
    access(2, 1, 0, BASE + 32, 4'hF, 0, st, rv);
    chk("rw_mem", 2, rv, 32'h55AA55AA);

    // Reset in the second stall cycle of a write
    access(1, 0, 1, BASE + 16, 4'hF, 32'h11223344, st, rv);
    rd[1] = 0; wr[1] = 1; ad[1] = BASE + 16; be[1] = 4'hF; wd[1] = 32'hFFFFFFFF;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; wr[1] = 0;
    chk("rst_count", 1, cnt[1], 32'd0);
    chk("rst_fault", 1, {31'd0, flt[1]}, 32'd0);
    access(1, 1, 0, BASE + 16, 4'hF, 0, st, rv);
    chk("rst_stall", 1, st, 2);
    chk("rst_mem", 1, rv, 32'h11223344);
    chk("rst_count1", 1, cnt[1], 32'd1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
